// File: rtl/prio_grant_encoder.sv
// Registered N-input priority encoder with a valid/ready grant output.
// RR=0 grants the highest set request; RR=1 rotates priority after each accepted grant.
module prio_grant_encoder #(
  parameter int N  = 8,
  parameter int RR = 0,
  parameter int W  = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         grant_ready,
  output logic         grant_valid,
  output logic [W-1:0] grant_idx,
  output logic [N-1:0] grant_onehot
);

  logic         grant_valid_q, grant_valid_d;
  logic [W-1:0] grant_idx_q, grant_idx_d;
  logic [N-1:0] grant_onehot_q, grant_onehot_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic         accept;
  logic         load;
  logic         any_req;
  logic [W-1:0] fixed_win;
  logic [W-1:0] rr_win;
  logic [W-1:0] win;

  // Highest set bit of r; later (higher) hits overwrite earlier ones.
  function automatic logic [W-1:0] fixed_pick(input logic [N-1:0] r);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++) begin
      if (r[i]) w = W'(i);
    end
    return w;
  endfunction

  // First set bit in the order p, p-1, ..., 0, N-1, ..., p+1.
  function automatic logic [W-1:0] rr_pick(input logic [N-1:0] r, input logic [W-1:0] p);
    logic [W-1:0] w;
    logic         hit;
    int           pos;
    w   = '0;
    hit = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos = int'(p) - k;
      if (pos < 0) pos = pos + N;
      if (!hit && r[pos]) begin
        w   = W'(pos);
        hit = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic logic [N-1:0] to_onehot(input logic [W-1:0] idx);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) begin
      v[i] = (W'(i) == idx);
    end
    return v;
  endfunction

  assign accept  = grant_valid_q && grant_ready;
  assign load    = !grant_valid_q || grant_ready;
  assign any_req = |req;

  // The just-served channel drops to lowest priority; wrap is to N-1, not 2^W-1.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      if (grant_idx_q == '0) ptr_d = W'(N - 1);
      else                   ptr_d = grant_idx_q - 1'b1;
    end
  end

  // Search uses the post-accept pointer so a requester cannot win twice in a row.
  always_comb begin
    fixed_win = fixed_pick(req);
    rr_win    = rr_pick(req, ptr_d);
    win       = (RR != 0) ? rr_win : fixed_win;
  end

  always_comb begin
    grant_valid_d  = grant_valid_q;
    grant_idx_d    = grant_idx_q;
    grant_onehot_d = grant_onehot_q;
    if (load) begin
      grant_valid_d = any_req;
      if (any_req) begin
        grant_idx_d    = win;
        grant_onehot_d = to_onehot(win);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_valid_q  <= 1'b0;
      grant_idx_q    <= '0;
      grant_onehot_q <= '0;
      ptr_q          <= W'(N - 1);
    end else begin
      grant_valid_q  <= grant_valid_d;
      grant_idx_q    <= grant_idx_d;
      grant_onehot_q <= grant_onehot_d;
      ptr_q          <= ptr_d;
    end
  end

  assign grant_valid  = grant_valid_q;
  assign grant_idx    = grant_idx_q;
  assign grant_onehot = grant_onehot_q;

endmodule

// File: tb/tb_prio_grant_encoder.sv
// Directed bench for prio_grant_encoder: fixed 8-input, round-robin 8-input
// and round-robin 5-input instances sharing one clock and reset.
module tb_prio_grant_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] req_f, req_r;
  logic [4:0] req_5;
  logic       rdy_f, rdy_r, rdy_5;
  logic       vld_f, vld_r, vld_5;
  logic [2:0] idx_f, idx_r, idx_5;
  logic [7:0] oh_f, oh_r;
  logic [4:0] oh_5;

  int checks = 0;
  int errors = 0;

  prio_grant_encoder #(.N(8), .RR(0)) u_fp (
    .clk(clk), .rst(rst), .req(req_f), .grant_ready(rdy_f),
    .grant_valid(vld_f), .grant_idx(idx_f), .grant_onehot(oh_f)
  );

  prio_grant_encoder #(.N(8), .RR(1)) u_rr (
    .clk(clk), .rst(rst), .req(req_r), .grant_ready(rdy_r),
    .grant_valid(vld_r), .grant_idx(idx_r), .grant_onehot(oh_r)
  );

  prio_grant_encoder #(.N(5), .RR(1)) u_rr5 (
    .clk(clk), .rst(rst), .req(req_5), .grant_ready(rdy_5),
    .grant_valid(vld_5), .grant_idx(idx_5), .grant_onehot(oh_5)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_f = '0; req_r = '0; req_5 = '0;
    rdy_f = 1'b0; rdy_r = 1'b0; rdy_5 = 1'b0;
    #3;
    checks++;
    if ({vld_f, idx_f, oh_f} !== 12'h000) begin
      errors++; $display("FAIL reset_fp: got v=%b i=%0d oh=%h expected 0/0/00", vld_f, idx_f, oh_f);
    end
    checks++;
    if ({vld_r, idx_r, oh_r} !== 12'h000) begin
      errors++; $display("FAIL reset_rr: got v=%b i=%0d oh=%h expected 0/0/00", vld_r, idx_r, oh_r);
    end
    checks++;
    if ({vld_5, idx_5, oh_5} !== 9'h000) begin
      errors++; $display("FAIL reset_rr5: got v=%b i=%0d oh=%h expected 0/0/00", vld_5, idx_5, oh_5);
    end
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_fixed_encode;
    req_f = 8'b0010_1100;
    rdy_f = 1'b1;
    tick;
    checks++;
    if (vld_f !== 1'b1 || idx_f !== 3'd5 || oh_f !== 8'h20) begin
      errors++; $display("FAIL fixed_encode: got v=%b i=%0d oh=%h expected 1/5/20", vld_f, idx_f, oh_f);
    end
  endtask

  task automatic test_backpressure;
    rdy_f = 1'b0;
    req_f = 8'h80;
    for (int c = 0; c < 3; c++) begin
      tick;
      checks++;
      if (vld_f !== 1'b1 || idx_f !== 3'd5 || oh_f !== 8'h20) begin
        errors++; $display("FAIL hold_cycle%0d: got v=%b i=%0d oh=%h expected 1/5/20", c, vld_f, idx_f, oh_f);
      end
    end
    rdy_f = 1'b1;
    tick;
    rdy_f = 1'b0;
    checks++;
    if (vld_f !== 1'b1 || idx_f !== 3'd7 || oh_f !== 8'h80) begin
      errors++; $display("FAIL hold_release: got v=%b i=%0d oh=%h expected 1/7/80", vld_f, idx_f, oh_f);
    end
  endtask

  task automatic test_fixed_sparse;
    req_f = 8'h11;
    rdy_f = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick;
      checks++;
      if (vld_f !== 1'b1 || idx_f !== 3'd4 || oh_f !== 8'h10) begin
        errors++; $display("FAIL fixed_sparse%0d: got v=%b i=%0d oh=%h expected 1/4/10", c, vld_f, idx_f, oh_f);
      end
    end
    req_f = '0;
    rdy_f = 1'b0;
  endtask

  task automatic test_rr_all;
    int exp_seq [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    logic [7:0] exp_oh;
    req_r = 8'hFF;
    rdy_r = 1'b1;
    for (int c = 0; c < 9; c++) begin
      tick;
      exp_oh = 8'(1 << exp_seq[c]);
      checks++;
      if (vld_r !== 1'b1 || idx_r !== 3'(exp_seq[c]) || oh_r !== exp_oh) begin
        errors++; $display("FAIL rr_all%0d: got v=%b i=%0d oh=%h expected 1/%0d/%h", c, vld_r, idx_r, oh_r, exp_seq[c], exp_oh);
      end
    end
  endtask

  task automatic test_rr_sparse;
    int exp_seq [4] = '{4, 0, 4, 0};
    logic [7:0] exp_oh;
    req_r = 8'h11;
    rdy_r = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick;
      exp_oh = 8'(1 << exp_seq[c]);
      checks++;
      if (vld_r !== 1'b1 || idx_r !== 3'(exp_seq[c]) || oh_r !== exp_oh) begin
        errors++; $display("FAIL rr_sparse%0d: got v=%b i=%0d oh=%h expected 1/%0d/%h", c, vld_r, idx_r, oh_r, exp_seq[c], exp_oh);
      end
    end
  endtask

  task automatic test_idle;
    req_r = '0;
    rdy_r = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick;
      checks++;
      if (vld_r !== 1'b0) begin
        errors++; $display("FAIL idle%0d: got v=%b expected 0", c, vld_r);
      end
    end
  endtask

  task automatic test_async_reset;
    req_r = 8'hFF;
    rdy_r = 1'b0;
    tick;
    checks++;
    if (vld_r !== 1'b1) begin
      errors++; $display("FAIL pre_reset_hold: got v=%b expected 1", vld_r);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (vld_r !== 1'b0 || idx_r !== 3'd0 || oh_r !== 8'h00) begin
      errors++; $display("FAIL async_reset: got v=%b i=%0d oh=%h expected 0/0/00", vld_r, idx_r, oh_r);
    end
    #2;
    rst = 1'b0;
    rdy_r = 1'b1;
    tick;
    checks++;
    if (vld_r !== 1'b1 || idx_r !== 3'd7 || oh_r !== 8'h80) begin
      errors++; $display("FAIL post_reset_first: got v=%b i=%0d oh=%h expected 1/7/80", vld_r, idx_r, oh_r);
    end
  endtask

  task automatic test_rr_wrap_bit0;
    req_r = 8'h01;
    rdy_r = 1'b1;
    tick;
    checks++;
    if (vld_r !== 1'b1 || idx_r !== 3'd0 || oh_r !== 8'h01) begin
      errors++; $display("FAIL wrap_bit0: got v=%b i=%0d oh=%h expected 1/0/01", vld_r, idx_r, oh_r);
    end
    req_r = 8'hFF;
    tick;
    checks++;
    if (vld_r !== 1'b1 || idx_r !== 3'd7 || oh_r !== 8'h80) begin
      errors++; $display("FAIL wrap_after0: got v=%b i=%0d oh=%h expected 1/7/80", vld_r, idx_r, oh_r);
    end
    tick;
    checks++;
    if (vld_r !== 1'b1 || idx_r !== 3'd6 || oh_r !== 8'h40) begin
      errors++; $display("FAIL wrap_next: got v=%b i=%0d oh=%h expected 1/6/40", vld_r, idx_r, oh_r);
    end
    req_r = '0;
    rdy_r = 1'b0;
  endtask

  task automatic test_npot;
    int exp_seq [6] = '{4, 3, 2, 1, 0, 4};
    logic [4:0] exp_oh;
    req_5 = 5'b11111;
    rdy_5 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick;
      exp_oh = 5'(1 << exp_seq[c]);
      checks++;
      if (vld_5 !== 1'b1 || idx_5 !== 3'(exp_seq[c]) || oh_5 !== exp_oh) begin
        errors++; $display("FAIL npot%0d: got v=%b i=%0d oh=%h expected 1/%0d/%h", c, vld_5, idx_5, oh_5, exp_seq[c], exp_oh);
      end
      checks++;
      if (idx_5 > 3'd4) begin
        errors++; $display("FAIL npot_range%0d: got i=%0d expected at most 4", c, idx_5);
      end
    end
    req_5 = '0;
    rdy_5 = 1'b0;
  endtask

  initial begin
    test_reset;
    test_fixed_encode;
    test_backpressure;
    test_fixed_sparse;
    test_rr_all;
    test_rr_sparse;
    test_idle;
    test_async_reset;
    test_rr_wrap_bit0;
    test_npot;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prio_grant_encoder.md
# prio_grant_encoder

Parametrised, registered N-input priority encoder with a valid/ready grant output and a selectable round-robin mode. It samples a request vector, encodes the winning request into a binary index and a one-hot vector, and holds that grant stable until the downstream consumer accepts it. It is the generalised successor of the 8-to-3 fixed-priority encoder. It sits between request sources (interrupt lines, channel requests) and a single-consumer dispatch stage.

## Interface
- `N`, default 8: number of request inputs; legal range 2..64, need not be a power of two.
- `RR`, default 0: arbitration mode. 0 = fixed priority, highest index wins. 1 = round-robin.
- `W`, default `$clog2(N)`: derived index width. Must not be overridden.

- `clk`: input, 1 bit. Single clock; all logic is on its rising edge.
- `rst`: input, 1 bit. Asynchronous, active-high reset.
- `req`: input, N bits. Level request vector; bit i requests channel i.
- `grant_ready`: input, 1 bit. The consumer accepts the current grant.
- `grant_valid`: output, 1 bit. A grant is presented.
- `grant_idx`: output, W bits. Binary index of the granted request.
- `grant_onehot`: output, N bits. One-hot form of `grant_idx`.

## Operation
- **Output register state.** The block has two states. EMPTY is `grant_valid=0`. HELD is `grant_valid=1`.
- **Load condition.** The block loads when `!grant_valid || grant_ready`.
  - On a load with `req != 0`: register the winner into `grant_idx` and `grant_onehot`, and set `grant_valid=1`.
  - On a load with `req == 0`: clear `grant_valid`. `grant_idx` and `grant_onehot` keep their old values; they are don't-care while invalid.
- **Hold.** While `grant_valid && !grant_ready`, all grant outputs are frozen. `req` is ignored, including deassertion of the granted bit.
- **Fixed mode (`RR=0`).** The winner is the highest set bit of `req`.
- **Round-robin mode (`RR=1`).**
  - An internal pointer `ptr` (W bits) is the highest-priority position.
  - The search order is `ptr`, `ptr-1`, …, 0, N-1, …, `ptr+1`. The first set bit in that order wins.
- **Pointer update.** On accept (`grant_valid && grant_ready`), `ptr` is set to `grant_idx-1` modulo N. Index 0 wraps to N-1, not to 2^W-1. The just-served channel therefore becomes lowest priority.
- **Accept-and-load in the same cycle.** The search uses the post-accept pointer value (the next-state pointer, computed combinationally). This prevents the same requester from winning twice in a row while others are pending.
- **Pointer in fixed mode.** `ptr` is unused when `RR=0` and may be optimised away.
- **Output invariant.** `grant_onehot` always equals `1 << grant_idx` whenever `grant_valid=1`.
- **Invalid-input handling.** There is no simulation `$display` for invalid input. `req == 0` is a normal idle condition.

## Timing
- **Reset (asynchronous assert).** `grant_valid=0`, `grant_idx=0`, `grant_onehot=0`, `ptr=N-1`. This makes the first round-robin grant match fixed priority.
- **Reset mid-hold.** A pending grant is dropped immediately, and no accept is counted.
- **Latency.** One cycle from `req` sampled at a load edge to `grant_valid`/`grant_idx` visible after that edge.
- **Throughput.** One grant per cycle while `grant_ready=1`.
- **Registered outputs.** All outputs come straight from flops; there is no combinational path from `req` or `grant_ready` to any output.
- **Combinational path `grant_ready` → load enable.** This internal path is allowed.
- **Ready before valid.** `grant_ready` asserted while `grant_valid=0` has no effect except allowing the load.
- **Boundary conditions.**
  - Single request at bit 0 in round-robin: the block grants 0 and `ptr` wraps to N-1.
  - All bits set in round-robin: grants strictly descend and wrap.

## Test plan
1. **Fixed-priority encode.** `RR=0`, `N=8`, `req=8'b0010_1100`, `grant_ready=1` → next cycle `grant_valid=1`, `grant_idx=5`, `grant_onehot=8'b0010_0000`.
2. **Backpressure hold.** `RR=0`: grant idx 5 is held with `grant_ready=0` while `req` changes to `8'h80` for 3 cycles → outputs stay idx 5. Raise `grant_ready` for one cycle → the next cycle shows idx 7.
3. **Round-robin, all requesting.** `RR=1`, `N=8`, `req=8'hFF`, `grant_ready=1` held → `grant_idx` sequence is 7,6,5,4,3,2,1,0,7 on consecutive cycles.
4. **Round-robin, sparse fairness.** `RR=1`, `req=8'h11`, `grant_ready=1` → `grant_idx` sequence is 4,0,4,0. In fixed mode the same stimulus gives 4,4,4.
5. **Idle and asynchronous reset.**
   - `req=0` for 4 cycles → `grant_valid=0` throughout.
   - Assert `rst` mid-cycle while a grant is held → `grant_valid`, `grant_idx` and `grant_onehot` go to 0 without waiting for a clock edge.
   - After release with `req=8'hFF`, `RR=1` → first grant is 7.
6. **Non-power-of-two width.** `RR=1`, `N=5` (W=3), `req=5'b11111` → sequence 4,3,2,1,0,4. `grant_idx` never exceeds 4.
